// File: rtl/wb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_mem_arb
// Purpose  : Three-master Wishbone arbiter in front of the single QSPI memory
//            slave. It provides registered grant locking, round-robin or fixed
//            priority selection, and a bus timeout with a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module wb_mem_arb #(
  parameter int PRIO_RR = 1,
  parameter int TIMEOUT = 255,
  parameter int TOW     = $clog2(TIMEOUT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // M0: instruction fetch (read-only)
  input  logic        m0_stb_i,
  input  logic [31:0] m0_adr_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // M1: CPU data port
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // M2: auxiliary master
  input  logic        m2_stb_i,
  input  logic        m2_we_i,
  input  logic [3:0]  m2_be_i,
  input  logic [31:0] m2_adr_i,
  input  logic [31:0] m2_dat_i,
  output logic [31:0] m2_dat_o,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  // Slave side
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  // Status
  output logic [1:0]  gnt_o,
  output logic        busy_o,
  output logic        to_err_o,
  input  logic        clr_err_i
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic [1:0]  r_last;
  logic        r_to_err;

  logic [2:0]  w_req;
  logic        w_any;
  logic [1:0]  w_win;
  logic [1:0]  w_p0, w_p1, w_p2;
  logic        w_busy;
  logic        w_gstb;
  logic        w_gwe;
  logic [3:0]  w_gbe;
  logic [31:0] w_gadr;
  logic [31:0] w_gdat;
  logic        w_ack;
  logic        w_to;

  assign w_req  = {m2_stb_i, m1_stb_i, m0_stb_i};
  assign w_any  = |w_req;
  assign w_busy = (r_state == S_BUSY);

  // Winner selection: search order starts after the last completed grant
  // (round-robin) or follows the fixed ranking M1 > M0 > M2.
  always_comb begin
    w_win = 2'd0;
    w_p0  = 2'd0;
    w_p1  = 2'd1;
    w_p2  = 2'd2;
    case (r_last)
      2'd0:    begin w_p0 = 2'd1; w_p1 = 2'd2; w_p2 = 2'd0; end
      2'd1:    begin w_p0 = 2'd2; w_p1 = 2'd0; w_p2 = 2'd1; end
      default: begin w_p0 = 2'd0; w_p1 = 2'd1; w_p2 = 2'd2; end
    endcase
    if (PRIO_RR != 0) begin
      // Later assignments override earlier ones, so w_p0 has highest rank.
      if (w_req[w_p2]) w_win = w_p2;
      if (w_req[w_p1]) w_win = w_p1;
      if (w_req[w_p0]) w_win = w_p0;
    end else begin
      if (w_req[2]) w_win = 2'd2;
      if (w_req[0]) w_win = 2'd0;
      if (w_req[1]) w_win = 2'd1;
    end
  end

  // Route the granted master's request; the fetch port is a full-word read.
  always_comb begin
    case (r_gnt)
      2'd0: begin
        w_gstb = m0_stb_i; w_gwe = 1'b0;    w_gbe = 4'hF;
        w_gadr = m0_adr_i; w_gdat = 32'd0;
      end
      2'd1: begin
        w_gstb = m1_stb_i; w_gwe = m1_we_i; w_gbe = m1_be_i;
        w_gadr = m1_adr_i; w_gdat = m1_dat_i;
      end
      default: begin
        w_gstb = m2_stb_i; w_gwe = m2_we_i; w_gbe = m2_be_i;
        w_gadr = m2_adr_i; w_gdat = m2_dat_i;
      end
    endcase
  end

  // Slave outputs are quiet outside BUSY so a dropped stb aborts immediately.
  assign s_stb_o = w_busy & w_gstb;
  assign s_we_o  = w_busy & w_gwe;
  assign s_be_o  = w_busy ? w_gbe  : 4'h0;
  assign s_adr_o = w_busy ? w_gadr : 32'd0;
  assign s_dat_o = w_busy ? w_gdat : 32'd0;

  // An ack counts only while the granted master still holds stb.
  assign w_ack = w_busy & w_gstb & s_ack_i;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [TOW-1:0] r_cnt;
      // Count BUSY cycles without ack; restarts from zero on every grant.
      always_ff @(posedge clk_i) begin
        if (rst_i || !w_busy) begin
          r_cnt <= '0;
        end else if (!s_ack_i && (r_cnt != TOW'(TIMEOUT - 1))) begin
          r_cnt <= r_cnt + TOW'(1);
        end
      end
      assign w_to = w_busy & w_gstb & ~s_ack_i & (r_cnt == TOW'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_to = 1'b0;
    end
  endgenerate

  // Grant FSM with the sticky timeout flag; every transaction ends in IDLE,
  // which inserts the one-cycle bubble before the next grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_gnt    <= 2'd0;
      r_last   <= 2'd2;
      r_to_err <= 1'b0;
    end else begin
      if (w_to) begin
        r_to_err <= 1'b1;
      end else if (clr_err_i) begin
        r_to_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_state <= S_BUSY;
          end
        end
        default: begin
          if (!w_gstb) begin
            r_state <= S_IDLE;
          end else if (s_ack_i || w_to) begin
            r_last  <= r_gnt;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;
  assign m0_ack_o = w_ack & (r_gnt == 2'd0);
  assign m1_ack_o = w_ack & (r_gnt == 2'd1);
  assign m2_ack_o = w_ack & (r_gnt == 2'd2);
  assign m0_err_o = w_to  & (r_gnt == 2'd0);
  assign m1_err_o = w_to  & (r_gnt == 2'd1);
  assign m2_err_o = w_to  & (r_gnt == 2'd2);

  assign gnt_o    = r_gnt;
  assign busy_o   = w_busy;
  assign to_err_o = r_to_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_mem_arb
// Purpose  : Directed self-checking bench for wb_mem_arb. A round-robin
//            instance and a fixed-priority instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mem_arb;

  logic        clk;
  logic        rst;
  logic        m0_stb;
  logic [31:0] m0_adr;
  logic        m1_stb, m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_adr, m1_dat;
  logic        m2_stb, m2_we;
  logic [3:0]  m2_be;
  logic [31:0] m2_adr, m2_dat;
  logic [31:0] s_dat_in;
  logic        s_ack;
  logic        clr_err;

  // Round-robin instance outputs
  logic [31:0] m0_rd, m1_rd, m2_rd;
  logic        m0_ack, m0_err, m1_ack, m1_err, m2_ack, m2_err;
  logic        s_stb, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_adr, s_wdat;
  logic [1:0]  gnt;
  logic        busy, to_err;

  // Fixed-priority instance outputs
  logic [31:0] f_m0_rd, f_m1_rd, f_m2_rd;
  logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_m2_ack, f_m2_err;
  logic        f_s_stb, f_s_we;
  logic [3:0]  f_s_be;
  logic [31:0] f_s_adr, f_s_wdat;
  logic [1:0]  f_gnt;
  logic        f_busy, f_to_err;

  int n_checks = 0;
  int n_errors = 0;

  wb_mem_arb #(.PRIO_RR(1), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_dat_o(m0_rd),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m2_stb_i(m2_stb), .m2_we_i(m2_we), .m2_be_i(m2_be), .m2_adr_i(m2_adr),
    .m2_dat_i(m2_dat), .m2_dat_o(m2_rd), .m2_ack_o(m2_ack), .m2_err_o(m2_err),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_be_o(s_be), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_dat_i(s_dat_in), .s_ack_i(s_ack),
    .gnt_o(gnt), .busy_o(busy), .to_err_o(to_err), .clr_err_i(clr_err)
  );

  wb_mem_arb #(.PRIO_RR(0), .TIMEOUT(4)) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_dat_o(f_m0_rd),
    .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat), .m1_dat_o(f_m1_rd), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
    .m2_stb_i(m2_stb), .m2_we_i(m2_we), .m2_be_i(m2_be), .m2_adr_i(m2_adr),
    .m2_dat_i(m2_dat), .m2_dat_o(f_m2_rd), .m2_ack_o(f_m2_ack), .m2_err_o(f_m2_err),
    .s_stb_o(f_s_stb), .s_we_o(f_s_we), .s_be_o(f_s_be), .s_adr_o(f_s_adr),
    .s_dat_o(f_s_wdat), .s_dat_i(s_dat_in), .s_ack_i(s_ack),
    .gnt_o(f_gnt), .busy_o(f_busy), .to_err_o(f_to_err), .clr_err_i(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout, wanted finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_exp [6];
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

    rst = 1'b1; clr_err = 1'b0; s_ack = 1'b0; s_dat_in = 32'd0;
    m0_stb = 1'b0; m0_adr = 32'd0;
    m1_stb = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_adr = 32'd0; m1_dat = 32'd0;
    m2_stb = 1'b0; m2_we = 1'b0; m2_be = 4'h0; m2_adr = 32'd0; m2_dat = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset busy",   32'(busy),   32'd0);
    chk("reset gnt",    32'(gnt),    32'd0);
    chk("reset s_stb",  32'(s_stb),  32'd0);
    chk("reset to_err", 32'(to_err), 32'd0);
    chk("reset m0_ack", 32'(m0_ack), 32'd0);

    // ---- Single M0 fetch, slave acks on the 3rd BUSY cycle ----
    m0_stb = 1'b1; m0_adr = 32'h100;
    #1;
    chk("m0 req idle s_stb", 32'(s_stb), 32'd0);
    tick();
    chk("m0 busy",   32'(busy),  32'd1);
    chk("m0 gnt",    32'(gnt),   32'd0);
    chk("m0 s_stb",  32'(s_stb), 32'd1);
    chk("m0 s_adr",  s_adr,      32'h100);
    chk("m0 s_be",   32'(s_be),  32'hF);
    chk("m0 s_we",   32'(s_we),  32'd0);
    chk("m0 no ack cyc1", 32'(m0_ack), 32'd0);
    tick();
    chk("m0 no ack cyc2", 32'(m0_ack), 32'd0);
    tick();
    s_ack = 1'b1; s_dat_in = 32'hCAFEF00D;
    #1;
    chk("m0 ack cyc3", 32'(m0_ack), 32'd1);
    chk("m0 rdata",    m0_rd,       32'hCAFEF00D);
    chk("m1 no ack",   32'(m1_ack), 32'd0);
    tick();
    s_ack = 1'b0;
    #1;
    chk("m0 bubble busy",  32'(busy),   32'd0);
    chk("m0 bubble s_stb", 32'(s_stb),  32'd0);
    chk("m0 bubble ack",   32'(m0_ack), 32'd0);
    m0_stb = 1'b0;
    tick();

    // ---- All three request continuously after reset, immediate acks ----
    rst = 1'b1;
    m0_stb = 1'b1; m0_adr = 32'h10;
    m1_stb = 1'b1; m1_adr = 32'h20;
    m2_stb = 1'b1; m2_adr = 32'h30;
    s_ack = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rr busy %0d", i), 32'(busy),   32'd1);
      chk($sformatf("rr gnt %0d", i),  32'(gnt),    32'(rr_exp[i]));
      chk($sformatf("fp gnt %0d", i),  32'(f_gnt),  32'd1);
      tick();
      chk($sformatf("rr bubble %0d", i), 32'(busy), 32'd0);
    end
    m0_stb = 1'b0; m1_stb = 1'b0; m2_stb = 1'b0; s_ack = 1'b0;
    tick();

    // ---- M1 write locked while M0 requests mid-transaction ----
    m1_stb = 1'b1; m1_we = 1'b1; m1_be = 4'h3; m1_adr = 32'h200; m1_dat = 32'h1234;
    tick();
    m0_stb = 1'b1; m0_adr = 32'h100;
    #1;
    chk("lock gnt",   32'(gnt),    32'd1);
    chk("lock s_adr", s_adr,       32'h200);
    chk("lock s_we",  32'(s_we),   32'd1);
    chk("lock s_be",  32'(s_be),   32'h3);
    chk("lock s_dat", s_wdat,      32'h1234);
    tick();
    chk("lock s_adr cyc2", s_adr,  32'h200);
    s_ack = 1'b1;
    #1;
    chk("lock m1 ack", 32'(m1_ack), 32'd1);
    chk("lock m0 no ack", 32'(m0_ack), 32'd0);
    tick();
    m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
    #1;
    chk("lock bubble busy",  32'(busy),  32'd0);
    chk("lock bubble s_stb", 32'(s_stb), 32'd0);
    tick();
    chk("m0 after bubble gnt", 32'(gnt), 32'd0);
    chk("m0 after bubble adr", s_adr,    32'h100);
    s_ack = 1'b1;
    #1;
    chk("m0 after bubble ack", 32'(m0_ack), 32'd1);
    tick();
    m0_stb = 1'b0; s_ack = 1'b0;
    tick();

    // ---- M2 timeout: err on 4th BUSY cycle, sticky flag ----
    m2_stb = 1'b1; m2_adr = 32'h300;
    tick();
    chk("to gnt",       32'(gnt),    32'd2);
    chk("to no err c1", 32'(m2_err), 32'd0);
    tick();
    tick();
    chk("to no err c3", 32'(m2_err), 32'd0);
    tick();
    chk("to err c4",    32'(m2_err), 32'd1);
    chk("to no ack c4", 32'(m2_ack), 32'd0);
    chk("to flag not yet", 32'(to_err), 32'd0);
    tick();
    chk("to flag set",  32'(to_err), 32'd1);
    chk("to idle",      32'(busy),   32'd0);
    chk("to err gone",  32'(m2_err), 32'd0);
    tick();
    chk("to regrant",   32'(busy),   32'd1);
    chk("to sticky",    32'(to_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    chk("to cleared",   32'(to_err), 32'd0);
    tick();
    tick();
    chk("to err again", 32'(m2_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    m2_stb = 1'b0;
    #1;
    chk("to set wins",  32'(to_err), 32'd1);

    // ---- Ack on the timeout cycle: ack wins ----
    clr_err = 1'b1; m2_stb = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    chk("ackto flag clr", 32'(to_err), 32'd0);
    chk("ackto busy",     32'(busy),   32'd1);
    tick();
    tick();
    tick();
    s_ack = 1'b1;
    #1;
    chk("ackto ack",  32'(m2_ack), 32'd1);
    chk("ackto err",  32'(m2_err), 32'd0);
    tick();
    m2_stb = 1'b0; s_ack = 1'b0;
    #1;
    chk("ackto flag", 32'(to_err), 32'd0);
    tick();

    // ---- Reset during a BUSY M1 write ----
    m1_stb = 1'b1; m1_we = 1'b1; m1_be = 4'hF; m1_adr = 32'h400;
    tick();
    chk("rst pre busy", 32'(busy), 32'd1);
    chk("rst pre gnt",  32'(gnt),  32'd1);
    rst = 1'b1; s_ack = 1'b1;
    tick();
    chk("rst busy",   32'(busy),   32'd0);
    chk("rst s_stb",  32'(s_stb),  32'd0);
    chk("rst gnt",    32'(gnt),    32'd0);
    chk("rst no ack", 32'(m1_ack), 32'd0);
    rst = 1'b0; s_ack = 1'b0;
    m0_stb = 1'b1; m2_stb = 1'b1;
    tick();
    chk("rst first gnt",  32'(gnt),  32'd0);
    chk("rst first busy", 32'(busy), 32'd1);
    m0_stb = 1'b0; m1_stb = 1'b0; m2_stb = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_mem_arb.md
Name: wb_mem_arb

Overview:
- Sequential Wishbone arbiter that shares the single QSPI memory slave (wb_qspi_mem) between three requesters.
  - M0: CPU instruction fetch, read-only.
  - M1: CPU data port.
  - M2: auxiliary master (debug or DMA).
- Replaces the combinational imem-over-dmem mux in front of the memory controller.
- Adds registered grant locking, round-robin fairness and a bus timeout. The timeout prevents a hung QSPI transfer from stalling the core forever.

Parameters:
- PRIO_RR, 1, 1 = round-robin arbitration; 0 = fixed priority M1 > M0 > M2.
- TIMEOUT, 255, number of BUSY cycles without ack before an error is returned; 0 disables the timeout.
- TOW, $clog2(TIMEOUT+1), timeout counter width (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- m0_stb_i  in  1  instruction fetch request.
- m0_adr_i  in  32  fetch address.
- m0_dat_o  out  32  read data.
- m0_ack_o  out  1  transfer done.
- m0_err_o  out  1  transfer timed out.
- m1_stb_i  in  1  data request.
- m1_we_i  in  1  write enable.
- m1_be_i  in  4  byte enables.
- m1_adr_i  in  32  address.
- m1_dat_i  in  32  write data.
- m1_dat_o  out  32  read data.
- m1_ack_o  out  1  done.
- m1_err_o  out  1  timed out.
- m2_stb_i / m2_we_i / m2_be_i / m2_adr_i / m2_dat_i / m2_dat_o / m2_ack_o / m2_err_o: same as M1.
- s_stb_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_be_o  out  4  slave byte enables.
- s_adr_o  out  32  slave address.
- s_dat_o  out  32  slave write data.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- gnt_o  out  2  current grant (0..2); valid only while busy_o is high.
- busy_o  out  1  high in state BUSY.
- to_err_o  out  1  sticky timeout flag.
- clr_err_i  in  1  clears to_err_o.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State IDLE; gnt=0; last-granted pointer=2, so M0 wins the first round-robin round.
  - Timeout counter=0; to_err_o=0.
  - All outputs 0.
- FSM IDLE:
  - s_stb_o=0; all mX_ack_o and mX_err_o = 0.
  - If any mX_stb_i is high, register the winner into gnt and move to BUSY on the next edge.
- Arbitration, round-robin (PRIO_RR=1): search order starts at (last+1) mod 3 and wraps.
- Arbitration, fixed (PRIO_RR=0): M1, then M0, then M2.
- Arbitration latency: 1 cycle from request to s_stb_o.
- FSM BUSY, signal routing:
  - s_adr_o, s_we_o, s_be_o, s_dat_o are combinationally muxed from the granted master.
  - For M0: s_we_o=0, s_be_o=4'hF, s_dat_o=0.
  - s_stb_o equals the granted master's stb.
  - Grant is locked: other requests are ignored until the transaction ends.
- BUSY, ack:
  - If s_ack_i is high and the granted stb is high, pulse that master's ack_o in the same cycle.
  - last <= gnt; return to IDLE on the next edge.
- Read data: all mX_dat_o = s_dat_i (broadcast). Only the granted master sees ack/err.
- Mandatory bubble: exactly one IDLE cycle between consecutive transactions. This prevents a stale stb held during the ack cycle from being re-granted.
- Abort: if the granted master drops stb in BUSY, s_stb_o drops in the same cycle. Any s_ack_i in that cycle is ignored, and the FSM returns to IDLE on the next edge. Fairness is unaffected (last is not updated).
- Timeout counter (TIMEOUT>0):
  - Cleared on entry to BUSY; increments every BUSY cycle without ack.
  - When counter == TIMEOUT-1 and there is no ack: pulse the granted master's err_o (no ack), set to_err_o, return to IDLE, and update last.
  - The counter never wraps.
- Simultaneous events:
  - s_ack_i in the timeout cycle: ack wins, no err.
  - Timeout and clr_err_i in the same cycle: set wins.
- TIMEOUT=0: counter logic removed; err_o is constant 0.
- Reset mid-transaction: FSM returns to IDLE at the next edge and s_stb_o drops. Any in-flight slave ack after reset is ignored.
- Outputs: busy_o = (state==BUSY); gnt_o = gnt register.

Test Plan:
- Only M0 requests address 0x100; slave acks on the 3rd BUSY cycle -> s_stb_o rises 1 cycle after m0_stb_i, s_be_o=4'hF, s_we_o=0, m0_ack_o pulses once, then one IDLE cycle.
- M0, M1 and M2 all request continuously after reset, slave acks after 1 cycle, PRIO_RR=1 -> grants are 0,1,2,0,1,2; with PRIO_RR=0, M1 is always granted.
- M1 is granted and M0 requests mid-transaction -> s_adr_o stays at M1's address until the ack; M0 is granted only after the bubble cycle.
- TIMEOUT=4, slave never acks an M2 request -> m2_err_o pulses on the 4th BUSY cycle, to_err_o=1 sticky; clr_err_i clears it, and with a coincident new timeout it stays 1.
- s_ack_i arrives exactly on the timeout cycle -> ack is delivered, no err, to_err_o stays 0.
- rst_i asserted during a BUSY M1 write -> next cycle: IDLE, s_stb_o=0, gnt_o=0; first grant after reset goes to M0 when all three request.
